// File: rtl/enc_pkg.sv
// Shared definitions for the sequential priority encoder.
package enc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam int ENC_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/lsb_index_find.sv
// Combinational lowest-set-bit finder: binary index plus exactly-one-bit flag.
module lsb_index_find
   import enc_pkg::*;
#(
   parameter  int WIDTH = ENC_WIDTH_DEFAULT,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             one_hot
);

   // Scan high to low so the lowest set bit is the one that sticks; all-zero gives 0.
   always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_W'(i);
      end
   end

   // Clearing the lowest set bit leaves nothing exactly when one bit was set.
   assign one_hot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: captures a request vector and emits one beat
// per set bit, lowest index first, with valid/ready on both sides.
module priority_encoder_seq
   import enc_pkg::*;
#(
   parameter  int WIDTH = ENC_WIDTH_DEFAULT,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_none,
   output logic             busy
);

   localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pend, pend_nxt;
   logic [IDX_W-1:0] find_idx, idx_nxt;
   logic             find_one_hot;
   logic             valid_nxt, last_nxt, none_nxt;
   logic             accept, xfer;

   assign in_ready = (state == ST_IDLE);
   assign busy     = (state == ST_EMIT);
   assign accept   = in_valid & in_ready;
   assign xfer     = out_valid & out_ready;

   // The finder looks at the vector that will be pending next cycle, so the
   // registered outputs always describe the bit currently on offer.
   lsb_index_find #(.WIDTH(WIDTH)) u_find (
      .vec     (pend_nxt),
      .idx     (find_idx),
      .one_hot (find_one_hot)
   );

   // Next pending vector: load on accept, drop the delivered bit on each beat.
   always_comb begin
      pend_nxt = pend;
      if (accept)    pend_nxt = in_vec;
      else if (xfer) pend_nxt = pend & ~(LSB_ONE << out_idx);
   end

   // Next state and next registered outputs; everything holds while stalled.
   always_comb begin
      state_nxt = state;
      valid_nxt = out_valid;
      idx_nxt   = out_idx;
      last_nxt  = out_last;
      none_nxt  = out_none;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_EMIT;
               valid_nxt = 1'b1;
               idx_nxt   = find_idx;
               // An empty vector still produces a single terminating beat.
               none_nxt  = (in_vec == '0);
               last_nxt  = find_one_hot | (in_vec == '0);
            end
         end
         ST_EMIT: begin
            if (xfer) begin
               if (out_last) begin
                  state_nxt = ST_IDLE;
                  valid_nxt = 1'b0;
                  idx_nxt   = '0;
                  last_nxt  = 1'b0;
                  none_nxt  = 1'b0;
               end else begin
                  idx_nxt   = find_idx;
                  last_nxt  = find_one_hot;
                  none_nxt  = 1'b0;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, pending vector and output registers; reset discards any pending bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pend      <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_none  <= 1'b0;
      end else begin
         state     <= state_nxt;
         pend      <= pend_nxt;
         out_valid <= valid_nxt;
         out_idx   <= idx_nxt;
         out_last  <= last_nxt;
         out_none  <= none_nxt;
      end
   end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Self-checking bench for priority_encoder_seq: directed table, hand-written
// stall/reset sequences, and random vectors against a bit-list model.
module tb_priority_encoder_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_vec;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic       out_last;
   logic       out_none;
   logic       busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int  idx;
      bit  last;
      bit  none;
   } beat_t;

   typedef struct {
      logic [7:0] vec;
      int         nbeats;
      int         first_idx;
      int         last_idx;
   } vec_rec_t;

   beat_t exp_q[$];

   priority_encoder_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_none  (out_none),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: list every set bit in ascending order; the highest one is last.
   function automatic void model_load(input logic [7:0] vec);
      int hi;
      exp_q.delete();
      if (vec == 8'h00) begin
         exp_q.push_back('{idx: 0, last: 1'b1, none: 1'b1});
      end else begin
         hi = 0;
         for (int i = 0; i < 8; i++) if (vec[i]) hi = i;
         for (int i = 0; i < 8; i++)
            if (vec[i]) exp_q.push_back('{idx: i, last: (i == hi), none: 1'b0});
      end
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_ready"}, in_ready, 1);
      chk({tag, "_busy"},  busy, 0);
   endtask

   // Sends one vector (called at a negedge, DUT idle) and drains all beats.
   task automatic run_vec(input logic [7:0] vec, input int stall_pct,
                          output int nbeats, output int first_idx,
                          output int last_idx, output int cycles);
      beat_t b;
      chk("accept_ready", in_ready, 1);
      model_load(vec);
      in_valid  = 1'b1;
      in_vec    = vec;
      out_ready = 1'b0;
      @(negedge clk);
      nbeats = 0; first_idx = -1; last_idx = -1; cycles = 0;
      while (exp_q.size() > 0 && cycles < 200) begin
         // Input side must be ignored while emitting.
         in_valid = 1'($urandom_range(1));
         in_vec   = 8'($urandom);
         b = exp_q[0];
         chk("beat_valid", out_valid, 1);
         chk("beat_busy",  busy, 1);
         chk("beat_inrdy", in_ready, 0);
         chk("beat_idx",   out_idx, b.idx);
         chk("beat_last",  out_last, b.last);
         chk("beat_none",  out_none, b.none);
         out_ready = ($urandom_range(99) >= stall_pct);
         if (out_ready) begin
            if (nbeats == 0) first_idx = int'(out_idx);
            last_idx = int'(out_idx);
            nbeats++;
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) in_valid = 1'b0;
         end
         cycles++;
         @(negedge clk);
      end
      if (exp_q.size() > 0) chk("drain_timeout", 0, 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk_idle("after_vec");
   endtask

   vec_rec_t tbl[6];

   initial begin
      int nb, fi, li, cy;

      tbl[0] = '{8'h01, 1, 0, 0};
      tbl[1] = '{8'h80, 1, 7, 7};
      tbl[2] = '{8'hA5, 4, 0, 7};
      tbl[3] = '{8'h00, 1, 0, 0};
      tbl[4] = '{8'h18, 2, 3, 4};
      tbl[5] = '{8'hFF, 8, 0, 7};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = 8'h00;
      #12;
      chk_idle("reset");
      chk("reset_idx",  out_idx, 0);
      chk("reset_last", out_last, 0);
      chk("reset_none", out_none, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("post_reset");

      // Directed table, no back-pressure: beats are back to back.
      for (int k = 0; k < 6; k++) begin
         run_vec(tbl[k].vec, 0, nb, fi, li, cy);
         chk("tbl_nbeats", nb, tbl[k].nbeats);
         chk("tbl_first",  fi, tbl[k].first_idx);
         chk("tbl_lastix", li, tbl[k].last_idx);
         chk("tbl_cycles", cy, tbl[k].nbeats);
         @(negedge clk);
      end

      // Stall: out_ready low for 4 cycles, idx=3 must hold.
      in_valid = 1'b1; in_vec = 8'h18; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; in_vec = 8'hFF;
      for (int s = 0; s < 4; s++) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_idx",   out_idx, 3);
         chk("stall_last",  out_last, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("stall_idx3", out_idx, 3);
      chk("stall_last3", out_last, 0);
      @(negedge clk);
      chk("stall_idx4", out_idx, 4);
      chk("stall_last4", out_last, 1);
      chk("stall_valid4", out_valid, 1);
      @(negedge clk);
      out_ready = 1'b0;
      chk_idle("stall_end");

      // Reset mid-emit of 8'hFF after three beats.
      in_valid = 1'b1; in_vec = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int s = 0; s < 3; s++) begin
         chk("pre_rst_idx", out_idx, s);
         @(negedge clk);
      end
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_idle("mid_rst");
      chk("mid_rst_idx",  out_idx, 0);
      chk("mid_rst_last", out_last, 0);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("no_more_beats", out_valid, 0);
      end
      out_ready = 1'b0;
      run_vec(8'h02, 0, nb, fi, li, cy);
      chk("after_rst_nb", nb, 1);
      chk("after_rst_ix", fi, 1);
      @(negedge clk);

      // Random vectors with random back-pressure; some forced to zero.
      for (int r = 0; r < 150; r++) begin
         logic [7:0] v;
         v = (r % 17 == 0) ? 8'h00 : 8'($urandom);
         run_vec(v, 30, nb, fi, li, cy);
         chk("rnd_nbeats", nb, (v == 8'h00) ? 1 : $countones(v));
         if ($urandom_range(1) == 1) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
